// File: rtl/option_feeder.sv
// Option feeder: loads per-line option lists into a circular FIFO and replays them round by round.
// Build with FEEDER_STALL_DETECT_EN to stop when a round removes no options.
module option_feeder #(
   parameter int SIZE     = 11,
   parameter int DEPTH    = 1024,
   parameter int CNT_W    = 7,
   parameter int KEEP_LAT = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    num_rows,
   input  logic [3:0]                    num_cols,
   input  logic                          load_valid,
   input  logic                          load_first,
   input  logic [SIZE-1:0]               load_data,
   input  logic                          load_done,
   input  logic                          keep,
   input  logic                          solved,
   input  logic                          unsolvable,
   output logic                          started,
   output logic                          new_line,
   output logic                          option_valid,
   output logic [SIZE-1:0]               option_out,
   output logic [2*SIZE-1:0][CNT_W-1:0]  old_options_amnt,
   output logic [CNT_W-1:0]              all_options_remaining,
   output logic [7:0]                    round,
   output logic                          busy,
   output logic                          load_overflow,
   output logic                          stuck
);
   localparam int NL = 2*SIZE;
   localparam int LW = $clog2(NL);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int DW = $clog2(KEEP_LAT+1);
   localparam int SW = CNT_W + LW + 1;
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic [3:0] {IDLE, LOAD, START, GAP, INDEX, OPTS, DRAIN, ROUND_END, DONE} state_t;

   state_t                         state_q, state_d;
   logic [LW-1:0]                  lineIdx_q, lineIdx_d, loadLine_q, loadLine_d, lastLine;
   logic [CNT_W-1:0]               optLeft_q, optLeft_d, newCount_q, newCount_d, allRem_q, shadowSum;
   logic [DW-1:0]                  drainCnt_q, drainCnt_d;
   logic [AW-1:0]                  wrPtr_q, rdPtr_q;
   logic [FW-1:0]                  fill_q;
   logic [SIZE-1:0]                mem [DEPTH];
   logic [KEEP_LAT-1:0][SIZE-1:0]  dlyData_q;
   logic [KEEP_LAT-1:0]            dlyValid_q;
   logic [NL-1:0][CNT_W-1:0]       shadow_q, old_q;
   logic [7:0]                     round_q;
   logic                           overflow_q;
   logic [SIZE-1:0]                popData, pushData;
   logic [SW-1:0]                  sumWide;
   logic                           pop, push, loadBeat, loadAccept, keepPush, full;
   logic                           shadowWr, snapshot, roundEnd;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == CMAX) ? v : v + CNT_W'(1);
   endfunction

   assign lastLine   = LW'(num_rows) + LW'(num_cols) - LW'(1);
   assign full       = (fill_q == FW'(DEPTH));
   assign popData    = mem[rdPtr_q];
   assign loadBeat   = load_valid && (state_q == IDLE || state_q == LOAD);
   assign loadAccept = loadBeat && !full;
   assign keepPush   = keep && dlyValid_q[KEEP_LAT-1] && (state_q == OPTS || state_q == DRAIN);
   assign push       = loadAccept || keepPush;
   assign pushData   = loadAccept ? load_data : dlyData_q[KEEP_LAT-1];

   // Saturating sum of the shadow table, used at snapshot and round end
   always_comb begin
      sumWide = '0;
      for (int i = 0; i < NL; i++) sumWide = sumWide + SW'(shadow_q[i]);
      shadowSum = (sumWide > SW'(CMAX)) ? CMAX : sumWide[CNT_W-1:0];
   end

`ifdef FEEDER_STALL_DETECT_EN
   logic stuck_q, stallHit;
   assign stallHit = (shadowSum == allRem_q) && ((round_q + 8'd1) != 8'd0);
   always_ff @(posedge clk) begin
      if (rst) stuck_q <= 1'b0;
      else if (state_q == ROUND_END && stallHit && !(solved || unsolvable)) stuck_q <= 1'b1;
   end
   assign stuck = stuck_q;
`else
   assign stuck = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lineIdx_d  = lineIdx_q;
      loadLine_d = loadLine_q;
      optLeft_d  = optLeft_q;
      drainCnt_d = drainCnt_q;
      newCount_d = newCount_q;
      pop        = 1'b0;
      shadowWr   = 1'b0;
      snapshot   = 1'b0;
      roundEnd   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d    = LOAD;
               loadLine_d = '0;
            end
         end
         LOAD: begin
            if (load_valid && load_first && loadLine_q != LW'(NL-1)) loadLine_d = loadLine_q + LW'(1);
            if (load_done) begin
               state_d  = START;
               snapshot = 1'b1;
            end
         end
         START: state_d = GAP;
         GAP: begin
            state_d   = INDEX;
            lineIdx_d = '0;
         end
         INDEX: begin
            newCount_d = '0;
            optLeft_d  = old_q[lineIdx_q];
            drainCnt_d = DW'(KEEP_LAT);
            state_d    = (old_q[lineIdx_q] == '0) ? DRAIN : OPTS;
         end
         OPTS: begin
            pop        = 1'b1;
            optLeft_d  = optLeft_q - CNT_W'(1);
            drainCnt_d = DW'(KEEP_LAT);
            if (optLeft_q == CNT_W'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            drainCnt_d = drainCnt_q - DW'(1);
            if (drainCnt_q == DW'(1)) begin
               shadowWr = 1'b1;
               if (lineIdx_q == lastLine) begin
                  state_d = ROUND_END;
               end else begin
                  state_d   = INDEX;
                  lineIdx_d = lineIdx_q + LW'(1);
               end
            end
         end
         ROUND_END: begin
            roundEnd  = 1'b1;
            state_d   = INDEX;
            lineIdx_d = '0;
`ifdef FEEDER_STALL_DETECT_EN
            if (stallHit) state_d = DONE;
`endif
         end
         default: ;
      endcase
      if (keepPush) newCount_d = satInc(newCount_q);
      if ((solved || unsolvable) && busy) state_d = DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lineIdx_q  <= '0;
         loadLine_q <= '0;
         optLeft_q  <= '0;
         drainCnt_q <= '0;
         newCount_q <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         fill_q     <= '0;
         dlyData_q  <= '0;
         dlyValid_q <= '0;
         shadow_q   <= '0;
         old_q      <= '0;
         allRem_q   <= '0;
         round_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lineIdx_q  <= lineIdx_d;
         loadLine_q <= loadLine_d;
         optLeft_q  <= optLeft_d;
         drainCnt_q <= drainCnt_d;
         newCount_q <= newCount_d;
         if (push) wrPtr_q <= wrPtr_q + AW'(1);
         if (pop) rdPtr_q <= rdPtr_q + AW'(1);
         fill_q <= fill_q + FW'(push) - FW'(pop);
         // Popped options age here until their keep decision arrives
         dlyValid_q[0] <= pop;
         dlyData_q[0]  <= popData;
         for (int i = 1; i < KEEP_LAT; i++) begin
            dlyValid_q[i] <= dlyValid_q[i-1];
            dlyData_q[i]  <= dlyData_q[i-1];
         end
         if (loadBeat && full) overflow_q <= 1'b1;
         if (loadAccept) shadow_q[loadLine_d] <= satInc(shadow_q[loadLine_d]);
         if (shadowWr) shadow_q[lineIdx_q] <= newCount_d;
         if (snapshot || roundEnd) begin
            old_q    <= shadow_q;
            allRem_q <= shadowSum;
         end
         if (roundEnd) round_q <= round_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr_q] <= pushData;
   end

   assign started               = (state_q == START);
   assign new_line              = (state_q == INDEX);
   assign option_valid          = (state_q == OPTS);
   assign option_out            = (state_q == INDEX) ? {{(SIZE-LW){1'b0}}, lineIdx_q} :
                                  (state_q == OPTS)  ? popData : '0;
   assign old_options_amnt      = old_q;
   assign all_options_remaining = allRem_q;
   assign round                 = round_q;
   assign busy                  = (state_q != IDLE) && (state_q != DONE);
   assign load_overflow         = overflow_q;

endmodule
